// File: rtl/muldiv_unit_if.sv
// ============================================================================
// muldiv_unit_if : request/result bundle for the iterative multiply/divide unit
// Revision 1.0
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO registers
// Revision 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  wire logic     clk,
  input  wire logic     reset,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_op;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_araw;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  // Operand capture: magnitudes for signed ops, raw values for unsigned ops
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;

  assign w_signed = ~bus.op[0];
  assign w_sa     = w_signed & bus.a[WIDTH-1];
  assign w_sb     = w_signed & bus.b[WIDTH-1];
  assign w_ma     = w_sa ? (~bus.a + 1'b1) : bus.a;
  assign w_mb     = w_sb ? (~bus.b + 1'b1) : bus.b;

  // One shift-add multiply step
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};

  // One restoring divide step; the shifted partial remainder needs WIDTH+1 bits
  logic [WIDTH:0]     w_rem;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_rem      = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem >= {1'b0, r_opnd});
  assign w_sub      = w_rem[WIDTH-1:0] - r_opnd;
  assign w_div_next = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                           : {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;
  logic               w_dbz;

  assign w_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rmd  = r_sa ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
  assign w_dbz  = r_op[1] && (r_opnd == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CALC;
      S_CALC:  if (r_cnt == c_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_opnd <= '0;
      r_araw <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op   <= bus.op;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_araw <= bus.a;
            r_cnt  <= '0;
            r_opnd <= bus.op[1] ? w_mb : w_ma;
            r_acc  <= bus.op[1] ? {{WIDTH{1'b0}}, w_ma} : {{WIDTH{1'b0}}, w_mb};
          end else begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
        S_CALC: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (!r_op[1]) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (w_dbz) begin
            r_hi  <= r_araw;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_hi <= w_rmd;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : scoreboard bench for muldiv_unit (WIDTH=32)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc_since_start = 0;
  logic prev_done = 1'b0;
  logic [2*W:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bif ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  // Reference: {div_by_zero, hi, lo} from wide native arithmetic
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [63:0] sx, sy, p, q, r;
    logic [63:0] up;
    sx = $signed({{32{x[W-1]}}, x});
    sy = $signed({{32{y[W-1]}}, y});
    model = '0;
    case (o)
      2'b00: begin p = sx * sy; model = {1'b0, p}; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; model = {1'b0, up}; end
      2'b10: begin
        if (y == '0) model = {1'b1, x, 32'hFFFF_FFFF};
        else begin q = sx / sy; r = sx % sy; model = {1'b0, r[31:0], q[31:0]}; end
      end
      default: begin
        if (y == '0) model = {1'b1, x, 32'hFFFF_FFFF};
        else model = {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  // Result monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (bif.done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, want no done", bif.hi, bif.lo);
      end else begin
        e = exp_q.pop_front();
        if ({bif.div_by_zero, bif.hi, bif.lo} !== e) begin
          errors++;
          $display("FAIL result: got dbz=%b hi=%h lo=%h, want dbz=%b hi=%h lo=%h",
                   bif.div_by_zero, bif.hi, bif.lo, e[2*W], e[2*W-1:W], e[W-1:0]);
        end
      end
    end
    if (prev_done) begin
      checks++;
      if (bif.done !== 1'b0 || bif.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width: got done=%b dbz=%b, want 0 0", bif.done, bif.div_by_zero);
      end
    end
    prev_done = (bif.done === 1'b1);
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bif.start = 1'b1; bif.op = o; bif.a = x; bif.b = y;
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    bif.start = 1'b0;
    cyc_since_start = 1;
    checks++;
    if (bif.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got %b want 1", bif.busy);
    end
  endtask

  task automatic wait_done();
    while (bif.done !== 1'b1 && cyc_since_start < 60) begin
      @(negedge clk);
      cyc_since_start++;
    end
    checks++;
    if (cyc_since_start != W + 2) begin
      errors++;
      $display("FAIL latency: got %0d cycles want %0d", cyc_since_start, W + 2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.start = 1'b0; bif.op = 2'b00; bif.a = '0; bif.b = '0;
    bif.hi_we = 1'b0; bif.lo_we = 1'b0; bif.wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bif.busy, bif.done, bif.div_by_zero, bif.hi, bif.lo} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
               bif.busy, bif.done, bif.div_by_zero, bif.hi, bif.lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done();
    @(negedge clk);
    issue(2'b00, 32'h1234_5678, 32'h8765_4321);
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    issue(2'b11, 32'd100, 32'd7);
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_div_signed();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    issue(2'b11, 32'd100, 32'd0);
    wait_done();
    @(negedge clk);
    issue(2'b10, 32'hFFFF_FF00, 32'd0);
    wait_done();
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd0);
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    issue(2'b00, 32'd5, 32'd6);
    @(negedge clk); cyc_since_start++;
    bif.start = 1'b1; bif.op = 2'b10; bif.a = 32'd99; bif.b = 32'd3;
    bif.hi_we = 1'b1; bif.wdata = 32'h1234;
    @(negedge clk); cyc_since_start++;
    bif.start = 1'b0; bif.hi_we = 1'b0;
    checks++;
    if (bif.hi !== 32'h64 || bif.lo !== 32'hFFFF_FFFF || bif.busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_in_calc: got busy=%b hi=%h lo=%h want 1 00000064 ffffffff",
               bif.busy, bif.hi, bif.lo);
    end
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    bif.hi_we = 1'b1; bif.wdata = 32'h1234;
    @(negedge clk);
    bif.hi_we = 1'b0;
    checks++;
    if (bif.hi !== 32'h1234 || bif.lo !== 32'd30) begin
      errors++;
      $display("FAIL mthi: got hi=%h lo=%h want 00001234 0000001e", bif.hi, bif.lo);
    end
    bif.hi_we = 1'b1; bif.lo_we = 1'b1; bif.wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    bif.hi_we = 1'b0; bif.lo_we = 1'b0;
    checks++;
    if (bif.hi !== 32'hA5A5_5A5A || bif.lo !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL mthi_mtlo: got hi=%h lo=%h want a5a55a5a a5a55a5a", bif.hi, bif.lo);
    end
    bif.lo_we = 1'b1; bif.wdata = 32'h5555;
    issue(2'b01, 32'd2, 32'd3);
    bif.lo_we = 1'b0;
    checks++;
    if (bif.lo !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL start_priority: got lo=%h want a5a55a5a", bif.lo);
    end
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bif.start = 1'b1; bif.op = 2'b01; bif.a = 32'd9; bif.b = 32'd9;
    @(negedge clk);
    bif.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bif.busy !== 1'b0 || bif.hi !== '0 || bif.lo !== '0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b hi=%h lo=%h want 0 0 0", bif.busy, bif.hi, bif.lo);
    end
    repeat (40) @(negedge clk);
    issue(2'b01, 32'd9, 32'd9);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_signed();
    test_div_zero();
    test_busy_ignore();
    test_mthi_mtlo();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending results want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit that sits beside the single-cycle ALU in the CPU datapath.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake.
- Holds results in architectural HI/LO registers, which also support direct MTHI/MTLO writes and continuous MFHI/MFLO reads.
- Generalises the ALU to WIDTH-bit operands with sequential behaviour the combinational ALU lacks.

Parameters:
WIDTH, 32, operand width and HI/LO register width; must be >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI: write wdata to HI
lo_we  input  1  MTLO: write wdata to LO
wdata  input  WIDTH  data for MTHI/MTLO
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO updated by an operation
div_by_zero  output  1  valid with done; set for DIV/DIVU with b=0
hi  output  WIDTH  HI register (MFHI)
lo  output  WIDTH  LO register (MFLO)

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high (reset).
- Reset value of all outputs: busy=0, done=0, div_by_zero=0, hi=0, lo=0. The FSM returns to IDLE.
- Reset mid-operation aborts the operation: no done pulse, and HI/LO clear to 0.
- FSM has three states: IDLE, CALC, FIX. busy = (state != IDLE), decoded from the registered state.
- IDLE:
  - If start=1 at an edge, latch op, |a| and |b| (magnitudes for signed ops; raw values for unsigned ops), and the operand signs. Clear the counter and go to CALC.
  - start takes priority over hi_we/lo_we in the same cycle; the write is dropped.
- CALC: performs one radix-2 step per edge for exactly WIDTH edges, then goes to FIX.
  - Multiply: shift-add on a 2*WIDTH-bit accumulator.
  - Divide: restoring algorithm on a 2*WIDTH-bit remainder:quotient register.
- FIX: one edge. Applies sign correction, writes HI/LO, sets done=1 for one cycle and div_by_zero as appropriate, and returns to IDLE.
- Latency: with start sampled at edge 0, HI/LO are written and done=1 after edge WIDTH+1. busy is high for WIDTH+1 cycles. A new start may be accepted in the cycle in which done=1.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product. For MULT, negate the product if the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder. For DIV, negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncating division).
  - Signed most-negative / -1: lo = most-negative value (wraps), hi = 0. No flag is raised.
  - Divide by zero: lo = all ones, hi = a unmodified, div_by_zero=1 with done. Latency is unchanged (the iteration still runs).
- start while busy=1: ignored, and the in-flight operation is unaffected.
- hi_we/lo_we:
  - In IDLE without start, the target register updates at the next edge. hi_we and lo_we may be asserted together.
  - While busy: ignored.
- hi/lo hold their previous values throughout CALC. They change only at FIX, on MTHI/MTLO, or on reset.
- done and div_by_zero are registered, deassert after one cycle, and are 0 at all other times.

Test Plan (WIDTH=32):
- Reset, then MULT a=0xFFFFFFFD (-3), b=7 -> busy rises the next cycle; done after edge 33. hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_by_zero=0.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Back-to-back DIVU 100/7 issued in the done cycle -> accepted, lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x64, div_by_zero=1 for exactly one cycle with done.
- During MULT 5*6: pulse start with DIV, and pulse hi_we with wdata=0x1234 -> both ignored. Result hi=0, lo=30. Then in IDLE, hi_we=1, wdata=0x1234 -> hi=0x1234 next edge, lo unchanged.
- Start MULTU 9*9, assert reset at edge 10 -> busy=0, hi=lo=0, no done pulse. A subsequent MULTU 9*9 -> lo=81.
